// File: rtl/alu_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv_iter
// Purpose  : Iterative RV32M multiply/divide unit (radix-2 shift-add multiply,
//            restoring divide) with valid/ready handshakes on both sides.
//            Optional macro MULDIV_ZERO_SKIP_EN: multiplies with a zero operand
//            bypass the iterative datapath and complete in one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module alu_muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            Z,
  output logic            busy
);

  localparam int              CW      = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   STEPS   = CW'(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [2:0]      op_f3;
  logic            neg;
  // hi:lo is the double-width working register; mcand holds the multiplicand
  // or the divisor. For a bypassed op, lo carries the precomputed result.
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] mcand;

  // ---------------------------------------------------------------------------
  // Accept-time decode
  // ---------------------------------------------------------------------------
  logic            op1_signed;
  logic            op2_signed;
  logic            sign1;
  logic            sign2;
  logic [XLEN-1:0] abs1;
  logic [XLEN-1:0] abs2;
  logic            div_by_zero;
  logic            overflow;
  logic            zero_skip;
  logic            special;
  logic [XLEN-1:0] special_result;
  logic            neg_init;

  assign op1_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b110);
  assign op2_signed = (funct3 == 3'b001) || (funct3 == 3'b100) ||
                      (funct3 == 3'b110);
  assign sign1 = op1_signed & operand1[XLEN-1];
  assign sign2 = op2_signed & operand2[XLEN-1];
  // -MIN_INT wraps to MIN_INT, which is still the correct unsigned magnitude
  assign abs1  = sign1 ? -operand1 : operand1;
  assign abs2  = sign2 ? -operand2 : operand2;

  assign div_by_zero = funct3[2] && (operand2 == '0);
  assign overflow    = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                       (operand1 == MIN_INT) && (operand2 == '1);

`ifdef MULDIV_ZERO_SKIP_EN
  assign zero_skip = !funct3[2] && ((operand1 == '0) || (operand2 == '0));
`else
  assign zero_skip = 1'b0;
`endif

  assign special = div_by_zero || overflow || zero_skip;

  // Remainder follows the dividend sign; everything else uses the xor of signs
  assign neg_init = (funct3 == 3'b110) ? sign1 : (sign1 ^ sign2);

  // Fixed results for the cases that never enter the iterative datapath
  always_comb begin
    special_result = '0;
    if (div_by_zero)
      special_result = funct3[1] ? operand1 : '1;
    else if (overflow)
      special_result = funct3[1] ? '0 : MIN_INT;
  end

  // ---------------------------------------------------------------------------
  // One radix-2 step of each algorithm
  // ---------------------------------------------------------------------------
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic            div_ok;
  logic [XLEN-1:0] div_diff;

  assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(XLEN+1){1'b0}});
  assign div_shift = {hi, lo[XLEN-1]};
  assign div_ok    = (div_shift >= {1'b0, mcand});
  // When the trial subtract succeeds the difference is below the divisor,
  // so the low XLEN bits are exact.
  assign div_diff  = div_shift[XLEN-1:0] - mcand;

  // ---------------------------------------------------------------------------
  // Sign fix-up and result selection once all steps are done
  // ---------------------------------------------------------------------------
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_signed;
  logic [XLEN-1:0]   div_raw;
  logic [XLEN-1:0]   final_value;

  assign prod        = {hi, lo};
  assign prod_signed = neg ? -prod : prod;
  assign div_raw     = op_f3[1] ? hi : lo;

  // Pick low/high product word or signed quotient/remainder
  always_comb begin
    final_value = '0;
    if (op_f3[2])
      final_value = neg ? -div_raw : div_raw;
    else if (op_f3[1:0] == 2'b00)
      final_value = prod_signed[XLEN-1:0];
    else
      final_value = prod_signed[2*XLEN-1:XLEN];
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Control FSM and datapath registers with registered result/Z/out_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      op_f3     <= 3'b000;
      neg       <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      mcand     <= '0;
      result    <= '0;
      Z         <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_f3 <= funct3;
            neg   <= neg_init;
            count <= '0;
            hi    <= '0;
            if (special) begin
              lo    <= special_result;
              mcand <= '0;
              state <= DONE;
            end else begin
              // Divide: lo = dividend, mcand = divisor.
              // Multiply: lo = multiplier, mcand = multiplicand.
              lo    <= funct3[2] ? abs1 : abs2;
              mcand <= funct3[2] ? abs2 : abs1;
              state <= CALC;
            end
          end
        end

        CALC: begin
          if (count == STEPS) begin
            result    <= final_value;
            Z         <= (final_value == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            count <= count + 1'b1;
            if (op_f3[2]) begin
              hi <= div_ok ? div_diff : div_shift[XLEN-1:0];
              lo <= {lo[XLEN-2:0], div_ok};
            end else begin
              hi <= mul_sum[XLEN:1];
              lo <= {mul_sum[0], lo[XLEN-1:1]};
            end
          end
        end

        DONE: begin
          if (!out_valid) begin
            // Bypassed op: publish the precomputed result one cycle after accept
            result    <= lo;
            Z         <= (lo == '0);
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_muldiv_iter
// Purpose  : Self-checking bench for alu_muldiv_iter (XLEN=32) against an
//            arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv_iter;

  localparam logic [31:0] MIN_INT = 32'h8000_0000;
  localparam int          LAT_CALC = 33;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] operand1 = '0;
  logic [31:0] operand2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        Z;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_muldiv_iter #(.XLEN(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .funct3   (funct3),
    .operand1 (operand1),
    .operand2 (operand2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .Z        (Z),
    .busy     (busy)
  );

  // Reference: RV32M semantics with 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    case (f)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN_INT && b == 32'hFFFF_FFFF) return MIN_INT;
        return 32'(int'(a) / int'(b));
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == MIN_INT && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(int'(a) % int'(b));
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'b100 || f == 3'b110) && a == MIN_INT && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_ZERO_SKIP_EN
    if (!f[2] && (a == 0 || b == 0)) return 1;
`endif
    return LAT_CALC;
  endfunction

  // Issue one op, scramble inputs after accept, wait for result, consume it
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic z, output int lat, output bit ready_leak);
    @(negedge clk);
    funct3 = f; operand1 = a; operand2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    funct3 = 3'($urandom); operand1 = $urandom; operand2 = $urandom;
    lat = 0; ready_leak = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) ready_leak = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    r = result; z = Z;
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", result); end
    n_checks++; if (Z !== 1'b0) begin n_fail++; $display("FAIL reset_Z got=%b exp=0", Z); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_directed();
    logic [2:0]  tf [14] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6, 3'd0, 3'd0};
    logic [31:0] ta [14] = '{32'd50, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd100, 32'd100,
                             32'd100, 32'd5, 32'd5, MIN_INT, MIN_INT, 32'd0, 32'd7};
    logic [31:0] tb [14] = '{32'd50, 32'd3, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd50,
                             32'd50, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd123, 32'd6};
    logic [31:0] te [14] = '{32'd2500, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2, 32'd2, 32'd2,
                             32'd0, 32'hFFFF_FFFF, 32'd5, MIN_INT, 32'd0, 32'd0, 32'd42};
    logic [31:0] r;
    logic        z;
    int          lat;
    bit          leak;
    int          exp_lat;
    for (int i = 0; i < 14; i++) begin
      do_op(tf[i], ta[i], tb[i], r, z, lat, leak);
      exp_lat = model_latency(tf[i], ta[i], tb[i]);
      n_checks++; if (r !== te[i]) begin n_fail++; $display("FAIL dir_result[%0d] f3=%0d got=%h exp=%h", i, tf[i], r, te[i]); end
      n_checks++; if (z !== (te[i] == 0)) begin n_fail++; $display("FAIL dir_Z[%0d] got=%b exp=%b", i, z, te[i] == 0); end
      n_checks++; if (lat != exp_lat) begin n_fail++; $display("FAIL dir_latency[%0d] got=%0d exp=%0d", i, lat, exp_lat); end
      n_checks++; if (leak !== 1'b0) begin n_fail++; $display("FAIL dir_in_ready_busy[%0d] got=1 exp=0", i); end
    end
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [31:0] e;
    logic        z;
    int          lat;
    bit          leak;
    int          exp_lat;
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = MIN_INT; b = 32'hFFFF_FFFF; end
        2: a = 32'd0;
        3: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 30); end
        default: ;
      endcase
      do_op(f, a, b, r, z, lat, leak);
      e = model(f, a, b);
      exp_lat = model_latency(f, a, b);
      n_checks++; if (r !== e) begin n_fail++; $display("FAIL rnd_result f3=%0d a=%h b=%h got=%h exp=%h", f, a, b, r, e); end
      n_checks++; if (z !== (e == 0)) begin n_fail++; $display("FAIL rnd_Z got=%b exp=%b", z, e == 0); end
      n_checks++; if (lat != exp_lat) begin n_fail++; $display("FAIL rnd_latency f3=%0d got=%0d exp=%0d", f, lat, exp_lat); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
    int          waited;
    a = $urandom; b = $urandom;
    e = model(3'b011, a, b);
    @(negedge clk);
    funct3 = 3'b011; operand1 = a; operand2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    waited = 0;
    while (!out_valid && waited < 200) begin @(posedge clk); #1; waited++; end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_timeout got=%b exp=1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; funct3 = 3'($urandom); operand1 = $urandom; operand2 = $urandom;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready); end
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid[%0d] got=%b exp=1", i, out_valid); end
      n_checks++; if (result !== e) begin n_fail++; $display("FAIL bp_result[%0d] got=%h exp=%h", i, result, e); end
      n_checks++; if (Z !== (e == 0)) begin n_fail++; $display("FAIL bp_Z[%0d] got=%b exp=%b", i, Z, e == 0); end
    end
    // Consume while a request is still offered: it must not be taken
    @(negedge clk); out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0; in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_consume got=%b exp=0", out_valid); end
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_bubble_busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_midop();
    logic [31:0] r;
    logic        z;
    int          lat;
    bit          leak;
    @(negedge clk);
    funct3 = 3'b100; operand1 = 32'd1000; operand2 = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); rst_n = 1'b0; #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_calc_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL rst_calc_result got=%h exp=0", result); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_calc_busy got=%b exp=0", busy); end
    repeat (10) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_in_ready got=%b exp=1", in_ready); end
    do_op(3'b000, 32'd7, 32'd6, r, z, lat, leak);
    n_checks++; if (r !== 32'd42) begin n_fail++; $display("FAIL rst_next_mul got=%h exp=%h", r, 32'd42); end
    // Reset while a result is held in DONE, away from any clock edge
    @(negedge clk);
    funct3 = 3'b101; operand1 = 32'd5; operand2 = 32'd0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #3;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_done_pre got=%b exp=1", out_valid); end
    rst_n = 1'b0; #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_done_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL rst_done_result got=%h exp=0", result); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    test_directed();
    test_random();
    test_backpressure();
    test_reset_midop();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
